// File: rtl/operand_fetch_unit.sv
// Operand fetch: 32x32 register file, per-register pending-write scoreboard with write-back bypass,
// and a one-entry output buffer toward execute. Optional hazard stall counter: OFU_STALL_COUNT_EN.
module operand_fetch_unit #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int ADDRW = 5,
   parameter int PENDW = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_issueValid,
   output logic             o_issueReady,
   input  logic [ADDRW-1:0] i_rs1,
   input  logic [ADDRW-1:0] i_rs2,
   input  logic [ADDRW-1:0] i_rd,
   input  logic             i_rdWrites,
   input  logic             i_wbValid,
   input  logic [ADDRW-1:0] i_wbRd,
   input  logic [XLEN-1:0]  i_wbData,
   output logic             o_opValid,
   input  logic             i_opReady,
   output logic [XLEN-1:0]  o_rs1Data,
   output logic [XLEN-1:0]  o_rs2Data,
   output logic [ADDRW-1:0] o_opRd,
   output logic             o_errSpurious,
   output logic [31:0]      o_stallCycles
);

   localparam logic [PENDW-1:0] PEND_MAX = '1;
   localparam logic [PENDW-1:0] PEND_ONE = PENDW'(1);

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t           r_state, w_state_nxt;
   logic [XLEN-1:0]  r_rf   [NREGS];
   logic [PENDW-1:0] r_pend [NREGS];
   logic [XLEN-1:0]  r_rs1Data, r_rs2Data;
   logic [ADDRW-1:0] r_opRd;
   logic             r_err;

   logic [PENDW-1:0] w_pend_rs1, w_pend_rs2, w_pend_rd;
   logic             w_haz_rs1, w_haz_rs2, w_rd_full;
   logic             w_out_free, w_accept, w_consume, w_wb_en;
   logic [XLEN-1:0]  w_rs1_val, w_rs2_val;
   logic [NREGS-1:0] w_inc, w_dec;

   assign o_opValid     = (r_state == S_FULL);
   assign o_rs1Data     = r_rs1Data;
   assign o_rs2Data     = r_rs2Data;
   assign o_opRd        = r_opRd;
   assign o_errSpurious = r_err;

   // A source only waits if its last pending write is not the one retiring this cycle.
   always_comb begin
      w_pend_rs1   = r_pend[i_rs1];
      w_pend_rs2   = r_pend[i_rs2];
      w_pend_rd    = r_pend[i_rd];
      w_haz_rs1    = (i_rs1 != '0) && (w_pend_rs1 != '0) &&
                     !(i_wbValid && (i_wbRd == i_rs1) && (w_pend_rs1 == PEND_ONE));
      w_haz_rs2    = (i_rs2 != '0) && (w_pend_rs2 != '0) &&
                     !(i_wbValid && (i_wbRd == i_rs2) && (w_pend_rs2 == PEND_ONE));
      w_rd_full    = i_rdWrites && (i_rd != '0) && (w_pend_rd == PEND_MAX) &&
                     !(i_wbValid && (i_wbRd == i_rd));
      w_out_free   = !o_opValid || i_opReady;
      o_issueReady = w_out_free && !w_haz_rs1 && !w_haz_rs2 && !w_rd_full;
      w_accept     = i_issueValid && o_issueReady;
      w_consume    = o_opValid && i_opReady;
      w_wb_en      = i_wbValid && (i_wbRd != '0);
      w_rs1_val    = (i_rs1 == '0) ? '0 :
                     (i_wbValid && (i_wbRd == i_rs1)) ? i_wbData : r_rf[i_rs1];
      w_rs2_val    = (i_rs2 == '0) ? '0 :
                     (i_wbValid && (i_wbRd == i_rs2)) ? i_wbData : r_rf[i_rs2];
   end

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int r = 1; r < NREGS; r++) begin
         w_inc[r] = w_accept && i_rdWrites && (i_rd == ADDRW'(r));
         w_dec[r] = i_wbValid && (i_wbRd == ADDRW'(r)) && (r_pend[r] != '0);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
         S_FULL:  if (w_consume && !w_accept) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rs1Data <= '0;
         r_rs2Data <= '0;
         r_opRd    <= '0;
      end else if (w_accept) begin
         r_rs1Data <= w_rs1_val;
         r_rs2Data <= w_rs2_val;
         r_opRd    <= i_rdWrites ? i_rd : '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int r = 0; r < NREGS; r++) r_rf[r] <= '0;
      end else if (w_wb_en) begin
         r_rf[i_wbRd] <= i_wbData;
      end
   end

   // x0 never gets a pending write, so its counter stays at its reset value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (w_inc[r] && !w_dec[r])      r_pend[r] <= r_pend[r] + PEND_ONE;
            else if (w_dec[r] && !w_inc[r]) r_pend[r] <= r_pend[r] - PEND_ONE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)                                  r_err <= 1'b0;
      else if (w_wb_en && (r_pend[i_wbRd] == '0)) r_err <= 1'b1;
   end

`ifdef OFU_STALL_COUNT_EN
   logic [31:0] r_stall;

   // Counts only hazard stalls; back-pressure from execute is excluded.
   always_ff @(posedge i_clk) begin
      if (i_rst)                                           r_stall <= '0;
      else if (i_issueValid && !o_issueReady && w_out_free) r_stall <= r_stall + 32'd1;
   end
   assign o_stallCycles = r_stall;
`else
   assign o_stallCycles = '0;
`endif

endmodule
